// File: rtl/lsu_word_rmw.sv
// Load/store unit between the core memory stage and a word-only data memory.
// Loads and word stores take one memory cycle. Byte and half stores do a
// read-modify-write. Results come back registered with a one-cycle pulse.
//
// Ports:
//   clk, reset              clock (rising edge), async active-high reset
//   req_valid/req_ready     request handshake (ready only while idle)
//   req_we, req_funct3      store flag and RISC-V size code (b/h/w/bu/hu)
//   req_addr, req_wdata     byte address and right-aligned store data
//   rsp_valid               one-cycle completion pulse
//   rsp_rdata, rsp_err      extended load result; error flag (misaligned/illegal)
//   mem_addr, mem_d         word-aligned memory address and write data
//   mem_wen, mem_q          memory write enable; combinational read data
module lsu_word_rmw #(
    parameter int unsigned DWIDTH = 32,
    parameter int unsigned AWIDTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [AWIDTH-1:0] req_addr,
    input  logic [DWIDTH-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DWIDTH-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_d,
    output logic              mem_wen,
    input  logic [DWIDTH-1:0] mem_q
);

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, RMW_WR, RESP} state_t;

    state_t state, state_n;

    logic [AWIDTH-1:0] addr_q, addr_n;
    logic [2:0]        f3_q, f3_n;
    logic [DWIDTH-1:0] wdata_q, wdata_n;
    logic [AWIDTH-1:0] mem_addr_n;
    logic [DWIDTH-1:0] mem_d_n, rsp_rdata_n;
    logic              mem_wen_n, rsp_valid_n, rsp_err_n;

    // Request decode, only meaningful while idle
    logic legal_f3, illegal, misaligned;
    always_comb begin
        legal_f3   = (req_funct3 == F3_B)  || (req_funct3 == F3_H) ||
                     (req_funct3 == F3_W)  || (req_funct3 == F3_BU) ||
                     (req_funct3 == F3_HU);
        illegal    = !legal_f3 || (req_we && req_funct3[2]);
        misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    end

    // Lane extraction for loads and lane insertion for sub-word stores
    logic [7:0]        lane_b;
    logic [15:0]       lane_h;
    logic [DWIDTH-1:0] load_ext, merged;
    always_comb begin
        lane_b = mem_q[{addr_q[1:0], 3'b000} +: 8];
        lane_h = mem_q[{addr_q[1], 4'b0000} +: 16];
        case (f3_q)
            F3_B:    load_ext = {{(DWIDTH-8){lane_b[7]}}, lane_b};
            F3_BU:   load_ext = {{(DWIDTH-8){1'b0}}, lane_b};
            F3_H:    load_ext = {{(DWIDTH-16){lane_h[15]}}, lane_h};
            F3_HU:   load_ext = {{(DWIDTH-16){1'b0}}, lane_h};
            default: load_ext = mem_q;
        endcase
        merged = mem_q;
        if (f3_q[0]) merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        else         merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end

    assign req_ready = (state == IDLE);

    // Next state and next values of every registered output
    always_comb begin
        state_n     = state;
        addr_n      = addr_q;
        f3_n        = f3_q;
        wdata_n     = wdata_q;
        mem_addr_n  = '0;
        mem_d_n     = '0;
        mem_wen_n   = 1'b0;
        rsp_valid_n = 1'b0;
        rsp_rdata_n = rsp_rdata;
        rsp_err_n   = rsp_err;

        case (state)
            IDLE: begin
                if (req_valid) begin
                    addr_n  = req_addr;
                    f3_n    = req_funct3;
                    wdata_n = req_wdata;
                    if (illegal || misaligned) begin
                        state_n   = RESP;
                        rsp_err_n = 1'b1;
                    end else if (!req_we) begin
                        state_n = LOAD;
                    end else if (req_funct3 == F3_W) begin
                        state_n = RMW_WR;
                        mem_d_n = req_wdata;
                    end else begin
                        state_n = RMW_RD;
                    end
                end
            end
            LOAD: begin
                rsp_rdata_n = load_ext;
                rsp_err_n   = 1'b0;
                state_n     = RESP;
            end
            RMW_RD: begin
                // mem_d doubles as the merge register for the write cycle
                mem_d_n = merged;
                state_n = RMW_WR;
            end
            RMW_WR: begin
                rsp_err_n = 1'b0;
                state_n   = RESP;
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase

        if (state_n == LOAD || state_n == RMW_RD || state_n == RMW_WR)
            mem_addr_n = {addr_n[AWIDTH-1:2], 2'b00};
        mem_wen_n   = (state_n == RMW_WR);
        rsp_valid_n = (state_n == RESP);
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            addr_q    <= '0;
            f3_q      <= '0;
            wdata_q   <= '0;
            mem_addr  <= '0;
            mem_d     <= '0;
            mem_wen   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_n;
            addr_q    <= addr_n;
            f3_q      <= f3_n;
            wdata_q   <= wdata_n;
            mem_addr  <= mem_addr_n;
            mem_d     <= mem_d_n;
            mem_wen   <= mem_wen_n;
            rsp_valid <= rsp_valid_n;
            rsp_rdata <= rsp_rdata_n;
            rsp_err   <= rsp_err_n;
        end
    end

endmodule

// File: tb/tb_lsu_word_rmw.sv
// Directed bench for lsu_word_rmw with a small word-addressed memory model.
module tb_lsu_word_rmw;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_d;
    logic        mem_wen;
    logic [31:0] mem_q;

    logic [31:0] mem [0:15];
    logic        preload = 1'b1;
    int          wr_count = 0;
    logic [31:0] last_wr_addr = '0;
    logic [31:0] last_wr_d = '0;

    int n_checks = 0;
    int n_fail   = 0;

    lsu_word_rmw #(.DWIDTH(32), .AWIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_addr(mem_addr), .mem_d(mem_d), .mem_wen(mem_wen), .mem_q(mem_q)
    );

    always #5 clk = ~clk;

    assign mem_q = mem[mem_addr[5:2]];

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
            mem[4] <= 32'h8899AABB;
        end else if (mem_wen) begin
            mem[mem_addr[5:2]] <= mem_d;
            wr_count     <= wr_count + 1;
            last_wr_addr <= mem_addr;
            last_wr_d    <= mem_d;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request (req_valid left high) and check latency and response
    task automatic run(input string tag, input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input int lat,
                       input logic err, input logic [31:0] rdata, input int wr_exp);
        int k;
        int w0;
        @(negedge clk);
        check({tag, " ready"}, 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        w0 = wr_count;
        @(posedge clk);
        k = 1;
        while (k <= 8) begin
            @(negedge clk);
            if (rsp_valid) break;
            k++;
        end
        check({tag, " latency"}, 32'(k), 32'(lat));
        check({tag, " err"}, 32'(rsp_err), 32'(err));
        check({tag, " rdata"}, rsp_rdata, rdata);
        check({tag, " ready_in_resp"}, 32'(req_ready), 32'd0);
        check({tag, " writes"}, 32'(wr_count - w0), 32'(wr_exp));
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // sb 0x10 interrupted by reset after stage RMW cycles (1: RMW_RD, 2: RMW_WR)
    task automatic reset_mid(input string tag, input int stage, input logic [31:0] word);
        int w0;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b000;
        req_addr   = 32'h10;
        req_wdata  = 32'h000000EE;
        w0 = wr_count;
        @(posedge clk);
        if (stage == 2) @(posedge clk);
        #1;
        reset     = 1'b1;
        req_valid = 1'b0;
        #1;
        check({tag, " mem_wen"}, 32'(mem_wen), 32'd0);
        check({tag, " mem_d"}, mem_d, 32'h0);
        check({tag, " mem_addr"}, mem_addr, 32'h0);
        check({tag, " rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, " rsp_rdata"}, rsp_rdata, 32'h0);
        check({tag, " rsp_err"}, 32'(rsp_err), 32'd0);
        check({tag, " req_ready"}, 32'(req_ready), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check({tag, " word"}, mem[4], word);
        check({tag, " writes"}, 32'(wr_count - w0), 32'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst rsp_rdata", rsp_rdata, 32'h0);
        check("rst rsp_err", 32'(rsp_err), 32'd0);
        check("rst mem_wen", 32'(mem_wen), 32'd0);
        check("rst mem_d", mem_d, 32'h0);
        check("rst mem_addr", mem_addr, 32'h0);
        check("rst req_ready", 32'(req_ready), 32'd1);
        preload = 1'b0;
        reset   = 1'b0;

        // Loads, back to back
        run("lw10",  1'b0, 3'b010, 32'h10, 32'h0, 2, 1'b0, 32'h8899AABB, 0);
        run("lb13",  1'b0, 3'b000, 32'h13, 32'h0, 2, 1'b0, 32'hFFFFFF88, 0);
        run("lbu13", 1'b0, 3'b100, 32'h13, 32'h0, 2, 1'b0, 32'h00000088, 0);
        run("lh12",  1'b0, 3'b001, 32'h12, 32'h0, 2, 1'b0, 32'hFFFF8899, 0);
        run("lhu10", 1'b0, 3'b101, 32'h10, 32'h0, 2, 1'b0, 32'h0000AABB, 0);
        run("lb10",  1'b0, 3'b000, 32'h10, 32'h0, 2, 1'b0, 32'hFFFFFFBB, 0);

        // Sub-word and word stores
        run("sb11", 1'b1, 3'b000, 32'h11, 32'h12345677, 3, 1'b0, 32'hFFFFFFBB, 1);
        check("sb11 wr_addr", last_wr_addr, 32'h10);
        check("sb11 wr_d", last_wr_d, 32'h889977BB);
        run("lw10b", 1'b0, 3'b010, 32'h10, 32'h0, 2, 1'b0, 32'h889977BB, 0);
        run("sh12", 1'b1, 3'b001, 32'h12, 32'h0000CAFE, 3, 1'b0, 32'h889977BB, 1);
        check("sh12 wr_d", last_wr_d, 32'hCAFE77BB);
        run("sw14", 1'b1, 3'b010, 32'h14, 32'hDEADBEEF, 2, 1'b0, 32'h889977BB, 1);
        check("sw14 wr_addr", last_wr_addr, 32'h14);
        run("lw14", 1'b0, 3'b010, 32'h14, 32'h0, 2, 1'b0, 32'hDEADBEEF, 0);

        // Errors: response after one cycle, rdata held, no write
        run("lw11",  1'b0, 3'b010, 32'h11, 32'h0, 1, 1'b1, 32'hDEADBEEF, 0);
        run("sh13",  1'b1, 3'b001, 32'h13, 32'h1234, 1, 1'b1, 32'hDEADBEEF, 0);
        run("f3_011", 1'b0, 3'b011, 32'h10, 32'h0, 1, 1'b1, 32'hDEADBEEF, 0);
        run("st100", 1'b1, 3'b100, 32'h10, 32'h55, 1, 1'b1, 32'hDEADBEEF, 0);
        run("lw10c", 1'b0, 3'b010, 32'h10, 32'h0, 2, 1'b0, 32'hCAFE77BB, 0);
        idle_cycle();

        // Reset during the read-modify-write
        reset_mid("rst_rd", 1, 32'hCAFE77BB);
        reset_mid("rst_wr", 2, 32'hCAFE77BB);
        run("sb10", 1'b1, 3'b000, 32'h10, 32'h00000011, 3, 1'b0, 32'h0, 1);
        run("lw10d", 1'b0, 3'b010, 32'h10, 32'h0, 2, 1'b0, 32'hCAFE7711, 0);
        idle_cycle();
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
